apb_requester: RTL and testbench

- APB requester (initiator) that drives the bus toward the APB-to-I2C bridge completer and any other completer on the segment.
- Converts single-word commands from an internal command port into APB transfers with SETUP and ACCESS phases.
- Returns read data, slave error and timeout status on a response port.
- Used by the test/system controller to program the I2C bridge: TX FIFO at 0x0, RX FIFO at 0x4, CONFIG at 0x8, TIMEOUT at 0xC.

---
 rtl/apb_requester.sv | 173 +++++++++++++++++
 tb/tb_apb_requester.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// APB requester: turns single-word commands into APB SETUP/ACCESS transfers
// and reports read data, slave error and timeout on a pulsed response port.
module apb_requester #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              RSP_TIMEOUT,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_ZERO;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state_r,       state_s;
    logic              psel_r,        psel_s;
    logic              penable_r,     penable_s;
    logic              pwrite_r,      pwrite_s;
    logic [ADDR_W-1:0] paddr_r,       paddr_s;
    logic [DATA_W-1:0] pwdata_r,      pwdata_s;
    logic              rsp_valid_r,   rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_r,   rsp_rdata_s;
    logic              rsp_error_r,   rsp_error_s;
    logic              rsp_timeout_r, rsp_timeout_s;
    logic [CNT_W-1:0]  wait_cnt_r,    wait_cnt_s;
    logic              timeout_hit_s;
    logic [CNT_W-1:0]  wait_inc_s;

    // Timeout fires on the last allowed ACCESS cycle; a disabled timeout never fires.
    always_comb begin
        if (TO_EN && (wait_cnt_r == CNT_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Saturating increment of the ACCESS wait counter.
    always_comb begin
        if (wait_cnt_r == CNT_MAX) begin
            wait_inc_s = wait_cnt_r;
        end else begin
            wait_inc_s = wait_cnt_r + CNT_ONE;
        end
    end

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
    always_comb begin
        state_s       = state_r;
        psel_s        = psel_r;
        penable_s     = penable_r;
        pwrite_s      = pwrite_r;
        paddr_s       = paddr_r;
        pwdata_s      = pwdata_r;
        rsp_valid_s   = 1'b0;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_error_s   = rsp_error_r;
        rsp_timeout_s = rsp_timeout_r;
        wait_cnt_s    = wait_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    pwrite_s = CMD_WRITE;
                    paddr_s  = CMD_ADDR;
                    pwdata_s = CMD_WDATA;
                    psel_s   = 1'b1;
                    state_s  = ST_SETUP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_s  = 1'b1;
                wait_cnt_s = CNT_ZERO;
                state_s    = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Completion wins over a timeout landing on the same edge.
                if (PREADY) begin
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = pwrite_r ? {DATA_W{1'b0}} : PRDATA;
                    rsp_error_s   = PSLVERR;
                    rsp_timeout_s = 1'b0;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    state_s       = ST_IDLE;
                end else if (timeout_hit_s) begin
                    rsp_valid_s   = 1'b1;
                    rsp_rdata_s   = {DATA_W{1'b0}};
                    rsp_error_s   = 1'b1;
                    rsp_timeout_s = 1'b1;
                    psel_s        = 1'b0;
                    penable_s     = 1'b0;
                    state_s       = ST_IDLE;
                end else begin
                    wait_cnt_s    = wait_inc_s;
                end
            end
            default: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r       <= ST_IDLE;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            pwdata_r      <= {DATA_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            wait_cnt_r    <= CNT_ZERO;
        end else begin
            state_r       <= state_s;
            psel_r        <= psel_s;
            penable_r     <= penable_s;
            pwrite_r      <= pwrite_s;
            paddr_r       <= paddr_s;
            pwdata_r      <= pwdata_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_error_r   <= rsp_error_s;
            rsp_timeout_r <= rsp_timeout_s;
            wait_cnt_r    <= wait_cnt_s;
        end
    end

    assign CMD_READY   = (state_r == ST_IDLE);
    assign PSELx       = psel_r;
    assign PENABLE     = penable_r;
    assign PWRITE      = pwrite_r;
    assign PADDR       = paddr_r;
    assign PWDATA      = pwdata_r;
    assign RSP_VALID   = rsp_valid_r;
    assign RSP_RDATA   = rsp_rdata_r;
    assign RSP_ERROR   = rsp_error_r;
    assign RSP_TIMEOUT = rsp_timeout_r;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: a small register-file completer plus a
// second instance built with the timeout disabled.
module tb_apb_requester;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        CMD_VALID;
    logic        CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] PRDATA;

    logic        CMD_READY, RSP_VALID, RSP_ERROR, RSP_TIMEOUT;
    logic        PSELx, PENABLE, PWRITE;
    logic [31:0] RSP_RDATA, PADDR, PWDATA;

    logic        u1_cmd_ready, u1_rsp_valid, u1_rsp_error, u1_rsp_timeout;
    logic        u1_psel, u1_penable, u1_pwrite;
    logic [31:0] u1_rsp_rdata, u1_paddr, u1_pwdata;

    logic [31:0] mem [4];
    logic [31:0] b2b_addr [4];
    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERROR(RSP_ERROR),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)) u1 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .CMD_VALID(CMD_VALID), .CMD_READY(u1_cmd_ready), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(u1_rsp_valid), .RSP_RDATA(u1_rsp_rdata), .RSP_ERROR(u1_rsp_error),
        .RSP_TIMEOUT(u1_rsp_timeout),
        .PSELx(u1_psel), .PENABLE(u1_penable), .PWRITE(u1_pwrite), .PADDR(u1_paddr),
        .PWDATA(u1_pwdata), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Completer register file: TX 0x0, RX 0x4, CONFIG 0x8, TIMEOUT 0xC.
    assign PRDATA = mem[PADDR[3:2]];
    always @(posedge PCLK) begin
        if (!PRESETn) begin
            mem[0] <= 32'h0;
            mem[1] <= 32'hDEAD_BEEF;
            mem[2] <= 32'h0;
            mem[3] <= 32'h0;
        end else if (PSELx && PENABLE && PREADY && PWRITE) begin
            mem[PADDR[3:2]] <= PWDATA;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Bus fields must not move while the requester owns the bus.
    logic        prev_psel = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    always @(negedge PCLK) begin
        if (PSELx === 1'b1 && prev_psel) begin
            check("addr_stable", PADDR, prev_addr);
            check("wdata_stable", PWDATA, prev_wdata);
        end
        prev_psel  <= (PSELx === 1'b1);
        prev_addr  <= PADDR;
        prev_wdata <= PWDATA;
    end

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    // waits < 0 keeps PREADY low forever; otherwise PREADY rises in ACCESS cycle waits+1.
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int waits, output int acc, output int sel);
        acc = 0;
        sel = 0;
        PREADY = 1'b0;
        CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d;
        cyc();
        CMD_VALID = 1'b0;
        for (int n = 0; n < 100 && RSP_VALID !== 1'b1; n++) begin
            if (PSELx === 1'b1) sel++;
            if (PSELx === 1'b1 && PENABLE === 1'b1) begin
                acc++;
                PREADY = ((waits >= 0) && (acc > waits)) ? 1'b1 : 1'b0;
            end
            cyc();
        end
        PREADY = 1'b0;
        check("rsp_pulse", {31'h0, RSP_VALID}, 32'h1);
    endtask

    initial begin
        int acc, sel, k, nrsp, u1_pulses;
        int acc_t [4];
        b2b_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        PRESETn = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0;
        CMD_ADDR = 32'h0; CMD_WDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        cyc(); cyc();
        check("rst_ready", {31'h0, CMD_READY}, 32'h1);
        check("rst_psel", {31'h0, PSELx}, 32'h0);
        check("rst_penable", {31'h0, PENABLE}, 32'h0);
        check("rst_rsp_valid", {31'h0, RSP_VALID}, 32'h0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_rdata", RSP_RDATA, 32'h0);
        PRESETn = 1'b1;
        cyc();

        // 1: zero-wait write to CONFIG, then read it back
        run_xfer(1'b1, 32'h8, 32'h0000_1234, 0, acc, sel);
        check("t1_sel_cycles", acc_t_int(sel), 32'd2);
        check("t1_acc_cycles", acc_t_int(acc), 32'd1);
        check("t1_err", {31'h0, RSP_ERROR}, 32'h0);
        check("t1_to", {31'h0, RSP_TIMEOUT}, 32'h0);
        check("t1_psel_idle", {31'h0, PSELx}, 32'h0);
        check("t1_ready", {31'h0, CMD_READY}, 32'h1);
        check("t1_mem", mem[2], 32'h0000_1234);
        run_xfer(1'b0, 32'h8, 32'h0, 0, acc, sel);
        check("t1_readback", RSP_RDATA, 32'h0000_1234);

        // 2: read with 3 wait states, then a write clears RSP_RDATA
        run_xfer(1'b0, 32'h4, 32'h0, 3, acc, sel);
        check("t2_acc_cycles", acc_t_int(acc), 32'd4);
        check("t2_rdata", RSP_RDATA, 32'hDEAD_BEEF);
        check("t2_err", {31'h0, RSP_ERROR}, 32'h0);
        run_xfer(1'b1, 32'h0, 32'h77, 0, acc, sel);
        check("t2_wr_rdata", RSP_RDATA, 32'h0);

        // 3: timeout after exactly 16 ACCESS cycles; the no-timeout build keeps waiting
        run_xfer(1'b1, 32'h10, 32'hBAD, -1, acc, sel);
        check("t3_acc_cycles", acc_t_int(acc), 32'd16);
        check("t3_err", {31'h0, RSP_ERROR}, 32'h1);
        check("t3_to", {31'h0, RSP_TIMEOUT}, 32'h1);
        check("t3_rdata", RSP_RDATA, 32'h0);
        check("t3_psel", {31'h0, PSELx}, 32'h0);
        u1_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (u1_rsp_valid === 1'b1) u1_pulses++;
            cyc();
        end
        check("t3_inf_pulses", acc_t_int(u1_pulses), 32'd0);
        check("t3_inf_psel", {31'h0, u1_psel}, 32'h1);
        check("t3_inf_penable", {31'h0, u1_penable}, 32'h1);
        PREADY = 1'b1;
        cyc();
        PREADY = 1'b0;
        check("t3_inf_done", {31'h0, u1_rsp_valid}, 32'h1);
        check("t3_inf_to", {31'h0, u1_rsp_timeout}, 32'h0);
        cyc();

        // 4: slave error, and PREADY on the 16th ACCESS cycle
        PSLVERR = 1'b1;
        run_xfer(1'b1, 32'h0, 32'h1, 0, acc, sel);
        PSLVERR = 1'b0;
        check("t4_slverr", {31'h0, RSP_ERROR}, 32'h1);
        check("t4_slverr_to", {31'h0, RSP_TIMEOUT}, 32'h0);
        run_xfer(1'b1, 32'h4, 32'h2, 15, acc, sel);
        check("t4_edge_acc", acc_t_int(acc), 32'd16);
        check("t4_edge_err", {31'h0, RSP_ERROR}, 32'h0);
        check("t4_edge_to", {31'h0, RSP_TIMEOUT}, 32'h0);
        cyc();

        // 5: back-to-back writes with CMD_VALID held high
        k = 0; nrsp = 0; PREADY = 1'b1; CMD_WRITE = 1'b1;
        for (int t = 0; t < 40 && nrsp < 4; t++) begin
            if (RSP_VALID === 1'b1) nrsp++;
            if (CMD_READY === 1'b1) begin
                if (k < 4) begin
                    CMD_VALID = 1'b1;
                    CMD_ADDR  = b2b_addr[k];
                    CMD_WDATA = 32'hA000_0000 + 32'(k);
                    acc_t[k]  = t;
                    k++;
                end else begin
                    CMD_VALID = 1'b0;
                end
            end
            cyc();
        end
        CMD_VALID = 1'b0; PREADY = 1'b0;
        check("t5_rsp_count", acc_t_int(nrsp), 32'd4);
        for (int i = 1; i < 4; i++) check("t5_spacing", acc_t_int(acc_t[i] - acc_t[i-1]), 32'd3);
        check("t5_mem0", mem[0], 32'hA000_0000);
        check("t5_mem3", mem[3], 32'hA000_0003);

        // 6: reset during ACCESS, then a normal write to 0xC
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h8; CMD_WDATA = 32'h99;
        cyc();
        CMD_VALID = 1'b0;
        cyc();
        check("t6_in_access", {31'h0, PENABLE}, 32'h1);
        PRESETn = 1'b0;
        cyc();
        PRESETn = 1'b1;
        check("t6_psel", {31'h0, PSELx}, 32'h0);
        check("t6_penable", {31'h0, PENABLE}, 32'h0);
        check("t6_rsp_valid", {31'h0, RSP_VALID}, 32'h0);
        check("t6_ready", {31'h0, CMD_READY}, 32'h1);
        run_xfer(1'b1, 32'hC, 32'h55, 0, acc, sel);
        check("t6_err", {31'h0, RSP_ERROR}, 32'h0);
        check("t6_mem", mem[3], 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [31:0] acc_t_int(input int v);
        return 32'(v);
    endfunction

endmodule
